// File: rtl/io_port_responder.sv
// io_port_responder: I/O-space responder for IN/OUT. It provides Port A and, when IO_TIMER_EN is defined, an 8-bit timer 0.
// Latency: a write is applied at its strobe edge; read data is registered and valid, with io_rvalid, one cycle after io_read.
// Backpressure: none; io_read and io_write may both be strobed on every cycle.
module io_port_responder (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_read,
  input  logic       io_write,
  input  logic [5:0] io_addr,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       io_rvalid,
  input  logic [7:0] pin_in,
  output logic [7:0] pin_out,
  output logic [7:0] pin_oe,
  output logic       irq_tov
);

  localparam logic [5:0] PORTA_ADDR = 6'h1B;
  localparam logic [5:0] DDRA_ADDR  = 6'h1A;
  localparam logic [5:0] PINA_ADDR  = 6'h19;
  localparam logic [5:0] TCNT0_ADDR = 6'h32;
  localparam logic [5:0] TCCR0_ADDR = 6'h33;
  localparam logic [5:0] TIFR_ADDR  = 6'h38;
  localparam logic [5:0] TIMSK_ADDR = 6'h39;

  logic [7:0] porta;
  logic [7:0] ddra;
  logic [7:0] pin_meta;
  logic [7:0] pina;
  logic [7:0] rd_mux;
  logic       wr_porta;
  logic       wr_ddra;

  assign wr_porta = io_write && (io_addr == PORTA_ADDR);
  assign wr_ddra  = io_write && (io_addr == DDRA_ADDR);

  assign pin_out = porta;
  assign pin_oe  = ddra;

  // pin_meta may go metastable; only pina is visible to the CPU
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      porta    <= 8'h00;
      ddra     <= 8'h00;
      pin_meta <= 8'h00;
      pina     <= 8'h00;
    end else begin
      pin_meta <= pin_in;
      pina     <= pin_meta;
      if (wr_porta) porta <= io_wdata;
      if (wr_ddra)  ddra  <= io_wdata;
    end
  end

`ifdef IO_TIMER_EN
  logic [7:0] tcnt0;
  logic [2:0] cs;
  logic [9:0] presc;
  logic [9:0] presc_lim;
  logic       presc_run;
  logic       tov0;
  logic       toie0;
  logic       tick;
  logic       ovf;
  logic       wr_tcnt0;
  logic       wr_tccr0;
  logic       wr_tifr;
  logic       wr_timsk;

  assign wr_tcnt0 = io_write && (io_addr == TCNT0_ADDR);
  assign wr_tccr0 = io_write && (io_addr == TCCR0_ADDR);
  assign wr_tifr  = io_write && (io_addr == TIFR_ADDR);
  assign wr_timsk = io_write && (io_addr == TIMSK_ADDR);

  always_comb begin
    presc_lim = 10'd0;
    presc_run = 1'b1;
    case (cs)
      3'd1:    presc_lim = 10'd0;
      3'd2:    presc_lim = 10'd7;
      3'd3:    presc_lim = 10'd63;
      3'd4:    presc_lim = 10'd255;
      3'd5:    presc_lim = 10'd1023;
      default: presc_run = 1'b0;
    endcase
  end

  assign tick    = presc_run && (presc == presc_lim);
  // A CPU write to TCNT0 suppresses both the increment and the overflow
  assign ovf     = tick && !wr_tcnt0 && (tcnt0 == 8'hFF);
  assign irq_tov = tov0 & toie0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt0 <= 8'h00;
      cs    <= 3'd0;
      presc <= 10'd0;
      tov0  <= 1'b0;
      toie0 <= 1'b0;
    end else begin
      if (wr_tccr0) begin
        cs    <= io_wdata[2:0];
        presc <= 10'd0;
      end else if (presc_run) begin
        presc <= tick ? 10'd0 : presc + 10'd1;
      end

      if (wr_tcnt0)  tcnt0 <= io_wdata;
      else if (tick) tcnt0 <= tcnt0 + 8'd1;

      if (ovf)                         tov0 <= 1'b1;
      else if (wr_tifr && io_wdata[0]) tov0 <= 1'b0;

      if (wr_timsk) toie0 <= io_wdata[0];
    end
  end
`else
  assign irq_tov = 1'b0;
`endif

  always_comb begin
    rd_mux = 8'h00;
    case (io_addr)
      PORTA_ADDR: rd_mux = porta;
      DDRA_ADDR:  rd_mux = ddra;
      PINA_ADDR:  rd_mux = pina;
`ifdef IO_TIMER_EN
      TCNT0_ADDR: rd_mux = tcnt0;
      TCCR0_ADDR: rd_mux = {5'b00000, cs};
      TIFR_ADDR:  rd_mux = {7'b0000000, tov0};
      TIMSK_ADDR: rd_mux = {7'b0000000, toie0};
`endif
      default:    rd_mux = 8'h00;
    endcase
  end

  // A read samples pre-edge state, so a same-cycle write is never visible to it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_rdata  <= 8'h00;
      io_rvalid <= 1'b0;
    end else begin
      io_rvalid <= io_read;
      if (io_read) io_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: a behavioural model is compared with the DUT on every cycle, and directed literal checks are applied at key points.
module tb_io_port_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       io_read = 1'b0;
  logic       io_write = 1'b0;
  logic [5:0] io_addr = 6'h00;
  logic [7:0] io_wdata = 8'h00;
  logic [7:0] io_rdata;
  logic       io_rvalid;
  logic [7:0] pin_in = 8'h00;
  logic [7:0] pin_out;
  logic [7:0] pin_oe;
  logic       irq_tov;

  always #5 clk = ~clk;

  io_port_responder dut (
    .clk       (clk),
    .reset     (reset),
    .io_read   (io_read),
    .io_write  (io_write),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_rvalid (io_rvalid),
    .pin_in    (pin_in),
    .pin_out   (pin_out),
    .pin_oe    (pin_oe),
    .irq_tov   (irq_tov)
  );

`ifdef IO_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
  endtask

  // Model state: plain integers, advanced once per clock edge
  int m_porta, m_ddra, m_tcnt, m_cs, m_phase, m_tov, m_toie, m_rdata, m_rvalid;
  int m_pinq[$] = '{0, 0};

  function automatic int divisor(input int cs);
    case (cs)
      1: return 1;
      2: return 8;
      3: return 64;
      4: return 256;
      5: return 1024;
      default: return 0;
    endcase
  endfunction

  function automatic int m_read(input int a);
    case (a)
      'h1B: return m_porta;
      'h1A: return m_ddra;
      'h19: return m_pinq[0];
      'h32: return TEN ? m_tcnt : 0;
      'h33: return TEN ? m_cs : 0;
      'h38: return TEN ? m_tov : 0;
      'h39: return TEN ? m_toie : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    int a, d;
    bit wr, tick, ovf;
    if (reset) begin
      m_porta = 0; m_ddra = 0; m_tcnt = 0; m_cs = 0; m_phase = 0;
      m_tov = 0; m_toie = 0; m_rdata = 0; m_rvalid = 0;
      m_pinq = '{0, 0};
    end else begin
      a = int'(io_addr);
      d = int'(io_wdata);
      wr = io_write;
      if (io_read) m_rdata = m_read(a);
      m_rvalid = io_read ? 1 : 0;
      tick = 0;
      ovf = 0;
      if (TEN && divisor(m_cs) != 0) begin
        m_phase = (m_phase + 1) % divisor(m_cs);
        tick = (m_phase == 0);
      end
      if (TEN && wr && a == 'h33) begin
        m_cs = d % 8;
        m_phase = 0;
      end
      if (TEN && wr && a == 'h32) m_tcnt = d;
      else if (tick) begin
        m_tcnt = m_tcnt + 1;
        if (m_tcnt == 256) begin
          m_tcnt = 0;
          ovf = 1;
        end
      end
      if (ovf) m_tov = 1;
      else if (TEN && wr && a == 'h38 && (d % 2) == 1) m_tov = 0;
      if (TEN && wr && a == 'h39) m_toie = d % 2;
      if (wr && a == 'h1B) m_porta = d;
      if (wr && a == 'h1A) m_ddra = d;
      m_pinq.push_back(int'(pin_in));
      void'(m_pinq.pop_front());
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_pin_out", pin_out, 8'(m_porta));
      chk("cyc_pin_oe", pin_oe, 8'(m_ddra));
      chk("cyc_rvalid", {7'b0, io_rvalid}, 8'(m_rvalid));
      chk("cyc_rdata", io_rdata, 8'(m_rdata));
      chk("cyc_irq", {7'b0, irq_tov}, 8'(m_tov & m_toie));
    end
  end

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    io_write = 1'b1; io_addr = a; io_wdata = d;
    @(posedge clk); #1;
    io_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    io_read = 1'b1; io_addr = a;
    @(posedge clk); #1;
    io_read = 1'b0;
  endtask

  task automatic rw(input logic [5:0] a, input logic [7:0] d);
    io_read = 1'b1; io_write = 1'b1; io_addr = a; io_wdata = d;
    @(posedge clk); #1;
    io_read = 1'b0; io_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 cmp_en = 1'b1;
    idle(2);
    chk("rst_pin_out", pin_out, 8'h00);
    chk("rst_pin_oe", pin_oe, 8'h00);
    chk("rst_rvalid", {7'b0, io_rvalid}, 8'h00);
    chk("rst_rdata", io_rdata, 8'h00);
    chk("rst_irq", {7'b0, irq_tov}, 8'h00);
    reset = 1'b0;
    idle(1);

    // Port A writes and readback
    wr(6'h1A, 8'hF0);
    chk("ddra_oe", pin_oe, 8'hF0);
    wr(6'h1B, 8'hA5);
    chk("porta_out", pin_out, 8'hA5);
    rd(6'h1B);
    chk("porta_rvalid", {7'b0, io_rvalid}, 8'h01);
    chk("porta_rdata", io_rdata, 8'hA5);
    idle(1);
    chk("rvalid_pulse", {7'b0, io_rvalid}, 8'h00);
    chk("rdata_hold", io_rdata, 8'hA5);

    // Synchroniser latency
    pin_in = 8'h3C;
    rd(6'h19);
    chk("pina_early", io_rdata, 8'h00);
    idle(1);
    rd(6'h19);
    chk("pina_late", io_rdata, 8'h3C);
    wr(6'h19, 8'hFF);
    rd(6'h19);
    chk("pina_ro", io_rdata, 8'h3C);

    // Simultaneous read and write, unmapped access
    wr(6'h1B, 8'h11);
    rw(6'h1B, 8'h22);
    chk("rw_old", io_rdata, 8'h11);
    chk("rw_out", pin_out, 8'h22);
    rd(6'h1B);
    chk("rw_new", io_rdata, 8'h22);
    wr(6'h00, 8'h55);
    rd(6'h00);
    chk("unmapped_rvalid", {7'b0, io_rvalid}, 8'h01);
    chk("unmapped_rdata", io_rdata, 8'h00);

`ifdef IO_TIMER_EN
    // Overflow at divide-by-1, then W1C
    wr(6'h39, 8'h01);
    wr(6'h32, 8'hFE);
    wr(6'h33, 8'h01);
    idle(2);
    chk("ovf_irq", {7'b0, irq_tov}, 8'h01);
    rd(6'h32);
    chk("ovf_tcnt", io_rdata, 8'h00);
    rd(6'h38);
    chk("ovf_tifr", io_rdata, 8'h01);
    wr(6'h38, 8'h01);
    chk("w1c_irq", {7'b0, irq_tov}, 8'h00);
    // Overflow and W1C on the same edge: set wins
    wr(6'h32, 8'hFF);
    wr(6'h38, 8'h01);
    rd(6'h38);
    chk("setwins_tifr", io_rdata, 8'h01);
    rd(6'h32);
    chk("wrwins_tcnt", io_rdata, 8'h01);
    wr(6'h33, 8'h00);
    wr(6'h39, 8'hFF);
    rd(6'h39);
    chk("timsk_mask", io_rdata, 8'h01);
    // Divide-by-8 and CPU write on a tick edge
    wr(6'h32, 8'h00);
    wr(6'h33, 8'h02);
    idle(7);
    rd(6'h32);
    chk("div8_before", io_rdata, 8'h00);
    rd(6'h32);
    chk("div8_after", io_rdata, 8'h01);
    idle(6);
    wr(6'h32, 8'h10);
    rd(6'h32);
    chk("tick_wr", io_rdata, 8'h10);
    wr(6'h33, 8'hFA);
    rd(6'h33);
    chk("tccr_mask", io_rdata, 8'h02);
    wr(6'h33, 8'h00);
    wr(6'h38, 8'h01);
`else
    wr(6'h39, 8'h01);
    wr(6'h32, 8'hAA);
    wr(6'h33, 8'h01);
    rd(6'h32);
    chk("notimer_tcnt", io_rdata, 8'h00);
    rd(6'h33);
    chk("notimer_tccr", io_rdata, 8'h00);
    idle(3);
    chk("notimer_irq", {7'b0, irq_tov}, 8'h00);
`endif

    // Reset while counting, with a read strobe pending
    wr(6'h33, 8'h01);
    wr(6'h1A, 8'h0F);
    io_read = 1'b1; io_addr = 6'h1B;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    io_read = 1'b0;
    chk("midrst_out", pin_out, 8'h00);
    chk("midrst_oe", pin_oe, 8'h00);
    chk("midrst_rvalid", {7'b0, io_rvalid}, 8'h00);
    chk("midrst_rdata", io_rdata, 8'h00);
    chk("midrst_irq", {7'b0, irq_tov}, 8'h00);
    idle(1);
    reset = 1'b0;
    idle(2);
    chk("postrst_rvalid", {7'b0, io_rvalid}, 8'h00);
    rd(6'h32);
    chk("postrst_tcnt", io_rdata, 8'h00);
    idle(2);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
